xbus_ram_responder: RTL and testbench
=====================================

// Module: xbus_ram_responder
// PURPOSE
//  Dual-channel shared RAM that is the passive responder end of the MC3999 XBus handshake.
//  Each channel has two XBus ports:
//   - address port a<n>: write-only; the MC writes a cell pointer to it.
//   - data port d<n>: read or written by the MC; every access auto-advances that channel's pointer.
//  Sits beside MC cores on the board; both channels share one memory array.
// PARAMETERS
//  WIDTH  11  XBus data width, in bits
//  DEPTH  14  number of memory cells (>=2)
//  PTR_W  4   pointer width, ceil(log2(DEPTH))
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  a0_in, a1_in   in   WIDTH  address-port data from MC (ch0/ch1)
//  a0_write_in, a1_write_in    in   1  MC is writing the address port
//  a0_read_out, a1_read_out    out  1  address word accepted (ack pulse)
//  d0_in, d1_in   in   WIDTH  data-port write data from MC
//  d0_write_in, d1_write_in    in   1  MC is writing the data port
//  d0_read_out, d1_read_out    out  1  data word accepted (ack pulse)
//  d0_read_in, d1_read_in      in   1  MC is reading the data port
//  d0_out, d1_out              out  WIDTH  read data to MC
//  d0_write_out, d1_write_out  out  1  d<n>_out valid
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - all outputs 0; both pointers 0; all DEPTH cells 0.
//   - reset mid-handshake aborts the transfer; no memory or pointer update.
//  Write accept (address or data port), per port:
//   - at a posedge with *_write_in=1 and that port's *_read_out=0: capture the data, act on it, set *_read_out=1.
//   - next posedge: *_read_out=0 unconditionally. It is a 1-cycle ack; the MC drops write on seeing it.
//   - write_in still high at the edge where read_out clears is not a new word.
//   - write_in high again after that is a new word.
//  Address write: value v taken as unsigned.
//   - v<DEPTH: ptr<=v.
//   - v>=DEPTH: ignored, pointer unchanged, still acked.
//  Data write: mem[ptr]<=d_in; pointer advances 1.
//  Read:
//   - at a posedge with d_read_in=1 and d_write_out=0: d_out<=mem[ptr] (snapshot, value before this edge's writes); d_write_out<=1.
//   - at a posedge with d_write_out=1: d_write_out<=0 and d_out<=0.
//   - if d_read_in=1 at that edge, the word is consumed and the pointer advances 1.
//   - if d_read_in=0, the read was abandoned: no advance.
//  Read latency: 1 cycle from d_read_in seen to valid. The word is held valid for exactly 1 cycle.
//  Pointer update per channel per edge:
//   - an accepted in-range address write has priority; it overrides any advance.
//   - otherwise ptr += (data-write accept) + (read consume), modulo DEPTH (DEPTH-1 wraps to 0).
//  Same-edge data ops use the pre-edge pointer.
//  Cross-channel, same edge, same cell:
//   - both write: ch0 wins; ch1 is still acked.
//   - one writes, one starts a read: the reader snapshots the old value.
//  Holding memory unchanged while d_write_out=1 does not refresh d_out; it stays a snapshot.
//  Pure register array; no combinational path from any input to any output.
// TESTING
//  1. Reset state:
//     - rst_n=0 then released -> all outputs 0.
//     - d0 read -> d0_out=0 with d0_write_out=1 for 1 cycle.
//  2. Write address, burst, read back:
//     - a0 write 5; d0 writes 100, 200.
//     - a0 write 5; d0 read x2 -> 100 then 200; ptr0=7.
//     - each ack is a 1-cycle pulse, 1 edge after write_in.
//  3. Pointer wrap:
//     - a1 write 13; d1 write 7, 8 -> mem[13]=7, mem[0]=8, ptr1=1.
//     - a1 write 20 -> acked, ptr1 stays 1.
//  4. Cross-channel collision:
//     - same edge: ch0 writes 111, ch1 writes 222, both to cell 3 -> mem[3]=111, both acked.
//     - ch0 write 9 to cell 4 on the same edge ch1 starts reading cell 4 (old 0) -> d1_out=0.
//  5. Abandoned read and priority:
//     - d0 read valid with d0_read_in dropped -> ptr0 unchanged.
//     - address write 2 on the same edge as a data write at ptr 6 -> mem[6] written, ptr0=2.
//  6. Reset mid-op: assert rst_n=0 while d0_write_out=1 and a1 ack pending -> all outputs 0, memory 0.

Source files
------------

// File: rtl/xbus_ram_responder.sv
// -----------------------------------------------------------------------------
// xbus_ram_responder
//
// Dual-channel shared RAM acting as the passive responder end of the MC3999
// XBus handshake. Each channel owns a cell pointer and two XBus ports:
//   - address port a<n>: write-only. The MC writes a cell pointer to it.
//   - data port d<n>: read or written by the MC. Every completed access
//     auto-advances that channel's pointer.
// Both channels share one register-based memory array.
//
// Ports
//   clk                          rising-edge clock
//   rst_n                        asynchronous active-low reset
//   a0_in / a1_in                address word from MC
//   a0_write_in / a1_write_in    MC is writing the address port
//   a0_read_out / a1_read_out    address word accepted (1-cycle ack)
//   d0_in / d1_in                data-port write data from MC
//   d0_write_in / d1_write_in    MC is writing the data port
//   d0_read_out / d1_read_out    data word accepted (1-cycle ack)
//   d0_read_in / d1_read_in      MC is reading the data port
//   d0_out / d1_out              read data to MC
//   d0_write_out / d1_write_out  d<n>_out valid (1-cycle)
//
// Every output comes straight from a flop. There is no combinational path
// from any input to any output.
// -----------------------------------------------------------------------------
module xbus_ram_responder #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 14,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a0_in,
    input  logic             a0_write_in,
    output logic             a0_read_out,
    input  logic [WIDTH-1:0] a1_in,
    input  logic             a1_write_in,
    output logic             a1_read_out,
    input  logic [WIDTH-1:0] d0_in,
    input  logic             d0_write_in,
    output logic             d0_read_out,
    input  logic             d0_read_in,
    output logic [WIDTH-1:0] d0_out,
    output logic             d0_write_out,
    input  logic [WIDTH-1:0] d1_in,
    input  logic             d1_write_in,
    output logic             d1_read_out,
    input  logic             d1_read_in,
    output logic [WIDTH-1:0] d1_out,
    output logic             d1_write_out
);

    localparam int NCH = 2;

    // Channel-indexed views of the ports, so both channels share one body of logic.
    logic [WIDTH-1:0] a_in       [NCH];
    logic             a_write_in [NCH];
    logic [WIDTH-1:0] d_in       [NCH];
    logic             d_write_in [NCH];
    logic             d_read_in  [NCH];

    // Registered per-channel state.
    logic             a_ack   [NCH];
    logic             d_ack   [NCH];
    logic             d_valid [NCH];
    logic [WIDTH-1:0] d_rdata [NCH];
    logic [PTR_W-1:0] ptr     [NCH];

    // Per-edge decisions.
    logic             a_accept   [NCH];
    logic             a_in_range [NCH];
    logic             wr_accept  [NCH];
    logic             rd_consume [NCH];
    logic [PTR_W-1:0] ptr_next   [NCH];
    logic [WIDTH-1:0] mem_rd     [NCH];

    logic [WIDTH-1:0] mem [DEPTH];

    assign a_in[0]       = a0_in;
    assign a_in[1]       = a1_in;
    assign a_write_in[0] = a0_write_in;
    assign a_write_in[1] = a1_write_in;
    assign d_in[0]       = d0_in;
    assign d_in[1]       = d1_in;
    assign d_write_in[0] = d0_write_in;
    assign d_write_in[1] = d1_write_in;
    assign d_read_in[0]  = d0_read_in;
    assign d_read_in[1]  = d1_read_in;

    assign a0_read_out  = a_ack[0];
    assign a1_read_out  = a_ack[1];
    assign d0_read_out  = d_ack[0];
    assign d1_read_out  = d_ack[1];
    assign d0_out       = d_rdata[0];
    assign d1_out       = d_rdata[1];
    assign d0_write_out = d_valid[0];
    assign d1_write_out = d_valid[1];

    // A write is accepted only while its ack is low. The edge that clears the ack
    // therefore never sees the same still-held word as a second write.
    // A read is consumed only if the MC still holds read_in while the word is valid.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            a_accept[c]   = a_write_in[c] & ~a_ack[c];
            a_in_range[c] = (a_in[c] < WIDTH'(DEPTH));
            wr_accept[c]  = d_write_in[c] & ~d_ack[c];
            rd_consume[c] = d_valid[c] & d_read_in[c];
        end
    end

    // Next pointer. An accepted in-range address write overrides any advance.
    // Otherwise the pointer advances by up to two (a data write and a read
    // consume on the same edge), wrapping modulo DEPTH. One extra bit holds
    // the unwrapped sum.
    always_comb begin
        logic [PTR_W:0] sum;
        sum = '0;
        for (int c = 0; c < NCH; c++) begin
            sum = {1'b0, ptr[c]}
                + (PTR_W+1)'(wr_accept[c])
                + (PTR_W+1)'(rd_consume[c]);
            if (sum >= (PTR_W+1)'(DEPTH)) begin
                sum = sum - (PTR_W+1)'(DEPTH);
            end
            if (a_accept[c] && a_in_range[c]) begin
                ptr_next[c] = a_in[c][PTR_W-1:0];
            end else begin
                ptr_next[c] = sum[PTR_W-1:0];
            end
        end
    end

    // Read mux at the pre-edge pointer. It sees memory before this edge's
    // writes, so a same-edge write from either channel is not visible.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            mem_rd[c] = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (ptr[c] == PTR_W'(i)) begin
                    mem_rd[c] = mem[i];
                end
            end
        end
    end

    // Channel handshake and pointer registers. A reset during a transfer drops
    // every ack and valid and leaves nothing half-updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                a_ack[c]   <= 1'b0;
                d_ack[c]   <= 1'b0;
                d_valid[c] <= 1'b0;
                d_rdata[c] <= '0;
                ptr[c]     <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                a_ack[c] <= a_accept[c];
                d_ack[c] <= wr_accept[c];
                ptr[c]   <= ptr_next[c];
                // The read word is a one-cycle snapshot. It is not refreshed
                // while valid, and it returns to zero when valid drops.
                if (d_valid[c]) begin
                    d_valid[c] <= 1'b0;
                    d_rdata[c] <= '0;
                end else if (d_read_in[c]) begin
                    d_valid[c] <= 1'b1;
                    d_rdata[c] <= mem_rd[c];
                end
            end
        end
    end

    // Shared memory. When both channels write the same cell on one edge,
    // channel 0 wins. Channel 1 is still acked by the handshake logic above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_accept[0] && (ptr[0] == PTR_W'(i))) begin
                    mem[i] <= d_in[0];
                end else if (wr_accept[1] && (ptr[1] == PTR_W'(i))) begin
                    mem[i] <= d_in[1];
                end
            end
        end
    end

endmodule

// File: tb/tb_xbus_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_xbus_ram_responder
//
// Directed self-checking bench for xbus_ram_responder (WIDTH=11, DEPTH=14).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point. Expected values are hand-derived from the responder's protocol.
// -----------------------------------------------------------------------------
module tb_xbus_ram_responder;

    logic        clk;
    logic        rst_n;
    logic [10:0] aIn    [2];
    logic        aWr    [2];
    logic        aAck   [2];
    logic [10:0] dIn    [2];
    logic        dWr    [2];
    logic        dAck   [2];
    logic        dRd    [2];
    logic [10:0] dOut   [2];
    logic        dValid [2];

    int errors = 0;
    int checks = 0;

    xbus_ram_responder #(.WIDTH(11), .DEPTH(14), .PTR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a0_in        (aIn[0]),
        .a0_write_in  (aWr[0]),
        .a0_read_out  (aAck[0]),
        .a1_in        (aIn[1]),
        .a1_write_in  (aWr[1]),
        .a1_read_out  (aAck[1]),
        .d0_in        (dIn[0]),
        .d0_write_in  (dWr[0]),
        .d0_read_out  (dAck[0]),
        .d0_read_in   (dRd[0]),
        .d0_out       (dOut[0]),
        .d0_write_out (dValid[0]),
        .d1_in        (dIn[1]),
        .d1_write_in  (dWr[1]),
        .d1_read_out  (dAck[1]),
        .d1_read_in   (dRd[1]),
        .d1_out       (dOut[1]),
        .d1_write_out (dValid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Lets the currently driven inputs act on one rising edge, then steps just past it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        for (int c = 0; c < 2; c++) begin
            aIn[c] = '0;
            aWr[c] = 1'b0;
            dIn[c] = '0;
            dWr[c] = 1'b0;
            dRd[c] = 1'b0;
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return {4'd0, aAck[0], aAck[1], dAck[0], dAck[1],
                dValid[0], dValid[1], dOut[0], dOut[1]};
    endfunction

    task automatic writeAddr(input int ch, input logic [10:0] v, input string tag);
        aIn[ch] = v;
        aWr[ch] = 1'b1;
        applyStimulus();
        checkOutput({tag, "_ack"}, 32'(aAck[ch]), 32'd1);
        aWr[ch] = 1'b0;
        applyStimulus();
        checkOutput({tag, "_ackclr"}, 32'(aAck[ch]), 32'd0);
    endtask

    // With hold set, write_in stays high through the edge that clears the ack.
    // That edge must not count as a second word.
    task automatic writeData(input int ch, input logic [10:0] v, input bit hold, input string tag);
        dIn[ch] = v;
        dWr[ch] = 1'b1;
        applyStimulus();
        checkOutput({tag, "_ack"}, 32'(dAck[ch]), 32'd1);
        if (!hold) dWr[ch] = 1'b0;
        applyStimulus();
        checkOutput({tag, "_ackclr"}, 32'(dAck[ch]), 32'd0);
        dWr[ch] = 1'b0;
    endtask

    // Full consumed read: valid one edge after read_in, then cleared to zero.
    task automatic readData(input int ch, input logic [10:0] expVal, input string tag);
        dRd[ch] = 1'b1;
        applyStimulus();
        checkOutput({tag, "_valid"}, 32'(dValid[ch]), 32'd1);
        checkOutput({tag, "_data"}, 32'(dOut[ch]), 32'(expVal));
        applyStimulus();
        dRd[ch] = 1'b0;
        checkOutput({tag, "_validclr"}, 32'(dValid[ch]), 32'd0);
        checkOutput({tag, "_dataclr"}, 32'(dOut[ch]), 32'd0);
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;

        // 1. Reset state, then a read of cell 0 returns 0.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("post_reset_outputs", allOutputs(), 32'd0);
        readData(0, 11'd0, "rst_read0");

        // 2. Burst write at cell 5 (second word held an extra edge), then read back.
        writeAddr(0, 11'd5, "t2_addr5");
        writeData(0, 11'd100, 1'b0, "t2_wr100");
        writeData(0, 11'd200, 1'b1, "t2_wr200_hold");
        writeAddr(0, 11'd5, "t2_addr5b");
        readData(0, 11'd100, "t2_rd100");
        readData(0, 11'd200, "t2_rd200");
        // The pointer should now be 7. A write lands there, and reading cell 7 shows it.
        writeData(0, 11'd77, 1'b0, "t2_wr77");
        writeAddr(0, 11'd7, "t2_addr7");
        readData(0, 11'd77, "t2_ptr7");

        // 3. Pointer wrap on channel 1, then an out-of-range address is acked but ignored.
        writeAddr(1, 11'd13, "t3_addr13");
        writeData(1, 11'd7, 1'b0, "t3_wr7");
        writeData(1, 11'd8, 1'b0, "t3_wr8");
        writeAddr(1, 11'd20, "t3_addr20");
        writeData(1, 11'd55, 1'b0, "t3_wr55");
        writeAddr(0, 11'd13, "t3_addr13_ch0");
        readData(0, 11'd7, "t3_rd_cell13");
        readData(0, 11'd8, "t3_rd_cell0");
        readData(0, 11'd55, "t3_rd_cell1");

        // 4a. Both channels write cell 3 on the same edge. Channel 0 wins and both are acked.
        writeAddr(0, 11'd3, "t4_addr3_ch0");
        writeAddr(1, 11'd3, "t4_addr3_ch1");
        dIn[0] = 11'd111;
        dIn[1] = 11'd222;
        dWr[0] = 1'b1;
        dWr[1] = 1'b1;
        applyStimulus();
        checkOutput("t4_coll_ack0", 32'(dAck[0]), 32'd1);
        checkOutput("t4_coll_ack1", 32'(dAck[1]), 32'd1);
        dWr[0] = 1'b0;
        dWr[1] = 1'b0;
        applyStimulus();
        writeAddr(0, 11'd3, "t4_addr3_chk");
        readData(0, 11'd111, "t4_rd_cell3");

        // 4b. Both pointers are at 4. Channel 0 writes 9 on the same edge that channel 1 starts reading.
        dIn[0] = 11'd9;
        dWr[0] = 1'b1;
        dRd[1] = 1'b1;
        applyStimulus();
        dWr[0] = 1'b0;
        checkOutput("t4_wr9_ack", 32'(dAck[0]), 32'd1);
        checkOutput("t4_snap_valid", 32'(dValid[1]), 32'd1);
        checkOutput("t4_snap_data", 32'(dOut[1]), 32'd0);
        applyStimulus();
        dRd[1] = 1'b0;
        checkOutput("t4_snap_validclr", 32'(dValid[1]), 32'd0);
        writeAddr(0, 11'd4, "t4_addr4");
        readData(0, 11'd9, "t4_rd_cell4");

        // 5a. Abandoned read does not advance the pointer.
        writeAddr(0, 11'd10, "t5_addr10");
        writeData(0, 11'd31, 1'b0, "t5_wr31");
        writeData(0, 11'd32, 1'b0, "t5_wr32");
        writeAddr(0, 11'd10, "t5_addr10b");
        dRd[0] = 1'b1;
        applyStimulus();
        dRd[0] = 1'b0;
        checkOutput("t5_abandon_valid", 32'(dValid[0]), 32'd1);
        checkOutput("t5_abandon_data", 32'(dOut[0]), 32'd31);
        applyStimulus();
        checkOutput("t5_abandon_validclr", 32'(dValid[0]), 32'd0);
        readData(0, 11'd31, "t5_rd_again");

        // 5b. An address write and a data write at pointer 6 on the same edge. Cell 6 is written and the pointer becomes 2.
        writeAddr(0, 11'd6, "t5_addr6");
        aIn[0] = 11'd2;
        aWr[0] = 1'b1;
        dIn[0] = 11'd123;
        dWr[0] = 1'b1;
        applyStimulus();
        checkOutput("t5_prio_aack", 32'(aAck[0]), 32'd1);
        checkOutput("t5_prio_dack", 32'(dAck[0]), 32'd1);
        aWr[0] = 1'b0;
        dWr[0] = 1'b0;
        applyStimulus();
        readData(0, 11'd0, "t5_rd_cell2");
        writeAddr(0, 11'd6, "t5_addr6b");
        readData(0, 11'd123, "t5_rd_cell6");

        // 6. Reset while a read word is valid and a channel 1 address ack is pending.
        dRd[0] = 1'b1;
        aIn[1] = 11'd1;
        aWr[1] = 1'b1;
        applyStimulus();
        checkOutput("t6_pre_valid", 32'(dValid[0]), 32'd1);
        checkOutput("t6_pre_aack1", 32'(aAck[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", allOutputs(), 32'd0);
        clearInputs();
        applyStimulus();
        rst_n = 1'b1;
        applyStimulus();
        checkOutput("t6_post_outputs", allOutputs(), 32'd0);
        readData(0, 11'd0, "t6_rd_cell0");
        writeAddr(1, 11'd6, "t6_addr6");
        readData(1, 11'd0, "t6_rd_cell6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
